// File: rtl/regfile_pkg.sv
// Shared widths, FSM encoding and round-robin helper for the regfile write arbiter.
// Pure declarations; no timing or flow-control behaviour of its own.
package regfile_pkg;

    localparam int REG_AW       = 5;
    localparam int DATA_W       = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int GID_W        = 2;
    localparam int MAX_REQ      = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [GID_W-1:0] rr_next(input logic [GID_W-1:0] winner, input int nreq);
        return GID_W'((int'(winner) + 1) % nreq);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle: NREQ lanes of valid/ready with packed dest address and data.
// Requesters hold addr/data while valid && !ready; a transfer is valid[i] && ready[i].
interface regfile_write_arbiter_if #(
    parameter int NREQ = 2
);
    import regfile_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*REG_AW-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr (mod NREQ) wins; purely combinational.
// Produces a one-hot grant plus its index; no grant when nothing is requesting.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [GID_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [GID_W-1:0] idx,
    output logic             any
);

    // Padding to MAX_REQ lanes lets a GID_W-bit index address the vector exactly.
    logic [MAX_REQ-1:0] req_pad;
    logic [GID_W-1:0]   pos;

    assign req_pad = MAX_REQ'(req);

    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = GID_W'((int'(ptr) + k) % NREQ);
            if (!any && req_pad[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
    end

    assign gnt = any ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port among NREQ writeback requesters after an init sweep; 1-cycle write latency.
// Ready is a combinational one-hot round-robin grant, 1 write/cycle; REGWR_ZERO_GUARD_EN drops RUN writes to $zero.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int                NREQ          = 2,
    parameter int                NUM_REGS      = NUM_REGS_DEF,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0,
    parameter int                INIT_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    regfile_write_arbiter_if.slave   req,
    output logic                     Write,
    output logic [REG_AW-1:0]        WriteRegister,
    output logic [DATA_W-1:0]        WriteData,
    output logic [GID_W-1:0]         grant_id,
    output logic                     init_done
);

    // One extra count value marks "all registers written", giving exactly NUM_REGS write cycles.
    localparam int     PTR_W       = $clog2(NUM_REGS + 1);
    localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

    state_t             state_q;
    state_t             state_d;
    logic [PTR_W-1:0]   init_ptr;
    logic               init_last;
    logic [GID_W-1:0]   rr_ptr;

    logic [NREQ-1:0]    gnt;
    logic [GID_W-1:0]   win_idx;
    logic               win_any;
    logic               fire;
    logic               issue;

    logic [REG_AW-1:0]  addr_lane [MAX_REQ];
    logic [DATA_W-1:0]  data_lane [MAX_REQ];
    logic [REG_AW-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;

    for (genvar g = 0; g < MAX_REQ; g++) begin : g_lane
        if (g < NREQ) begin : g_used
            assign addr_lane[g] = req.req_addr[g*REG_AW +: REG_AW];
            assign data_lane[g] = req.req_data[g*DATA_W +: DATA_W];
        end else begin : g_pad
            assign addr_lane[g] = '0;
            assign data_lane[g] = '0;
        end
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req (req.req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win_idx),
        .any (win_any)
    );

    assign win_addr  = addr_lane[win_idx];
    assign win_data  = data_lane[win_idx];
    assign init_last = (init_ptr == PTR_W'(NUM_REGS));

    assign req.req_ready = (reset_n && (state_q == ST_RUN)) ? gnt : '0;
    assign fire          = reset_n && (state_q == ST_RUN) && win_any;

`ifdef REGWR_ZERO_GUARD_EN
    // Accepted like any other transfer, but $zero is never written once running.
    assign issue = fire && (win_addr != '0);
`else
    assign issue = fire;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (init_last) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            init_ptr      <= '0;
            rr_ptr        <= '0;
            Write         <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            grant_id      <= '0;
            init_done     <= 1'b0;
        end else begin
            Write <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (!init_last) begin
                        Write         <= 1'b1;
                        WriteRegister <= REG_AW'(init_ptr);
                        WriteData     <= INIT_VALUE;
                        init_ptr      <= init_ptr + PTR_W'(1);
                    end else begin
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    init_done <= 1'b1;
                    if (fire) begin
                        rr_ptr <= rr_next(win_idx, NREQ);
                    end
                    if (issue) begin
                        Write         <= 1'b1;
                        WriteRegister <= win_addr;
                        WriteData     <= win_data;
                        grant_id      <= win_idx;
                    end
                end
                default: begin
                    init_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (NREQ=2) with a per-cycle reference model and literal spot checks.
module tb_regfile_write_arbiter;

`ifdef REGWR_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        Write;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [1:0]  grant_id;
    logic        init_done;

    logic [4:0]  a [2];
    logic [31:0] d [2];

    int total;
    int bad;

    regfile_write_arbiter_if #(.NREQ(2)) rif ();

    assign rif.req_addr = {a[1], a[0]};
    assign rif.req_data = {d[1], d[0]};

    regfile_write_arbiter #(
        .NREQ          (2),
        .NUM_REGS      (32),
        .INIT_VALUE    (32'h0),
        .INIT_ON_RESET (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (rif),
        .Write         (Write),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .grant_id      (grant_id),
        .init_done     (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] v, input int rr);
        for (int dd = 0; dd < 2; dd++) begin
            int j;
            j = (rr + dd) % 2;
            if (((v >> j) & 2'b01) != 2'b00) return j;
        end
        return -1;
    endfunction

    // Reference model: spec-level state (sweep count, rr pointer, expected port contents).
    int          m_cnt;
    int          m_rr;
    bit          m_run;
    bit          m_live;
    logic        e_w;
    logic [4:0]  e_reg;
    logic [31:0] e_dat;
    logic [1:0]  e_gid;
    logic        e_done;

    initial begin
        m_live = 1'b0;
        m_cnt  = 0;
        m_rr   = 0;
        m_run  = 1'b0;
        e_w    = 1'b0;
        e_reg  = '0;
        e_dat  = '0;
        e_gid  = '0;
        e_done = 1'b0;
    end

    always @(posedge clk) begin
        int w;
        if (!reset_n) begin
            m_cnt = 0; m_rr = 0; m_run = 1'b0;
            e_w = 1'b0; e_reg = '0; e_dat = '0; e_gid = '0; e_done = 1'b0;
        end else if (!m_run) begin
            if (m_cnt < 32) begin
                e_w = 1'b1; e_reg = 5'(m_cnt); e_dat = 32'h0; m_cnt++;
            end else begin
                e_w = 1'b0; m_run = 1'b1; e_done = 1'b1;
            end
        end else begin
            w   = pick(rif.req_valid, m_rr);
            e_w = 1'b0;
            if (w >= 0) begin
                m_rr = (w + 1) % 2;
                if (!(GUARD && a[w] == 5'd0)) begin
                    e_w = 1'b1; e_reg = a[w]; e_dat = d[w]; e_gid = 2'(w);
                end
            end
        end
        m_live = 1'b1;
    end

    always @(negedge clk) begin
        logic [1:0] e_rdy;
        int w;
        if (m_live) begin
            w     = pick(rif.req_valid, m_rr);
            e_rdy = (!reset_n || !m_run || w < 0) ? 2'b00 : 2'(1 << w);
            check("model_ready",     32'(rif.req_ready), 32'(e_rdy));
            check("model_write",     32'(Write),         32'(e_w));
            check("model_wreg",      32'(WriteRegister), 32'(e_reg));
            check("model_wdata",     WriteData,          e_dat);
            check("model_grant_id",  32'(grant_id),      32'(e_gid));
            check("model_init_done", 32'(init_done),     32'(e_done));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         good;
        int         wc;
        logic [3:0] gseq;
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        rif.req_valid = 2'b11;
        a[0] = 5'd3;  d[0] = 32'h55;
        a[1] = 5'd4;  d[1] = 32'h66;

        repeat (3) cyc();
        #1;
        check("reset_write",     32'(Write),         32'h0);
        check("reset_init_done", 32'(init_done),     32'h0);
        check("reset_ready",     32'(rif.req_ready), 32'h0);
        reset_n = 1'b1;

        // Init sweep: 32 writes of 0 to regs 0..31, requests ignored.
        good = 0;
        for (int n = 0; n < 32; n++) begin
            cyc();
            #1;
            if (Write === 1'b1 && WriteRegister === 5'(n) && WriteData === 32'h0 &&
                rif.req_ready === 2'b00 && init_done === 1'b0) good++;
        end
        check("init_sweep_cycles", 32'(good), 32'd32);
        cyc();
        #1;
        check("init_done_rise",  32'(init_done),     32'h1);
        check("init_end_write",  32'(Write),         32'h0);
        check("first_run_ready", 32'(rif.req_ready), 32'h1);

        // Both valid: alternating grants, a write every cycle.
        gseq = '0;
        wc   = 0;
        repeat (4) begin
            cyc();
            #1;
            gseq = {gseq[2:0], grant_id[0]};
            if (Write === 1'b1) wc++;
        end
        check("rr_grant_seq",  32'(gseq), 32'h5);
        check("rr_write_each", 32'(wc),   32'd4);
        rif.req_valid = 2'b00;
        cyc();
        #1;
        check("rr_idle_write", 32'(Write), 32'h0);

        // Single requester 1.
        rif.req_valid = 2'b10;
        a[1] = 5'd5; d[1] = 32'hDEADBEEF;
        #1;
        check("single_ready", 32'(rif.req_ready), 32'h2);
        cyc();
        #1;
        check("single_write", 32'(Write),         32'h1);
        check("single_wreg",  32'(WriteRegister), 32'd5);
        check("single_wdata", WriteData,          32'hDEADBEEF);
        check("single_gid",   32'(grant_id),      32'h1);
        rif.req_valid = 2'b00;
        cyc();
        #1;
        check("single_after", 32'(Write), 32'h0);

        // Same destination from both requesters: A then B back to back.
        rif.req_valid = 2'b11;
        a[0] = 5'd7; d[0] = 32'hA;
        a[1] = 5'd7; d[1] = 32'hB;
        #1;
        check("same_dst_ready0", 32'(rif.req_ready), 32'h1);
        cyc();
        #1;
        check("same_dst_first", WriteData, 32'hA);
        rif.req_valid = 2'b10;
        #1;
        check("same_dst_ready1", 32'(rif.req_ready), 32'h2);
        cyc();
        #1;
        check("same_dst_second", WriteData,          32'hB);
        check("same_dst_wreg",   32'(WriteRegister), 32'd7);
        check("same_dst_wen",    32'(Write),         32'h1);
        rif.req_valid = 2'b00;
        cyc();
        #1;
        check("same_dst_idle", 32'(Write), 32'h0);

        // Write to register 0.
        rif.req_valid = 2'b01;
        a[0] = 5'd0; d[0] = 32'h1234;
        #1;
        check("zero_ready", 32'(rif.req_ready), 32'h1);
        cyc();
        #1;
        if (GUARD) begin
            check("zero_guard_write", 32'(Write), 32'h0);
        end else begin
            check("zero_write", 32'(Write),         32'h1);
            check("zero_wreg",  32'(WriteRegister), 32'h0);
            check("zero_wdata", WriteData,          32'h1234);
        end
        rif.req_valid = 2'b10;
        a[1] = 5'd9; d[1] = 32'h77;
        #1;
        check("pre_reset_ready", 32'(rif.req_ready), 32'h2);

        // Reset in the cycle of a pending transfer.
        reset_n = 1'b0;
        #1;
        check("in_reset_ready", 32'(rif.req_ready), 32'h0);
        cyc();
        #1;
        check("reset_drop_write", 32'(Write),     32'h0);
        check("reset_init_clear", 32'(init_done), 32'h0);
        reset_n = 1'b1;
        rif.req_valid = 2'b00;
        cyc();
        #1;
        check("resweep_write", 32'(Write),         32'h1);
        check("resweep_reg0",  32'(WriteRegister), 32'h0);

        repeat (40) cyc();
        rif.req_valid = 2'b01;
        a[0] = 5'd12; d[0] = 32'h99;
        cyc();
        #1;
        rif.req_valid = 2'b00;
        check("post_resweep_write", 32'(Write),         32'h1);
        check("post_resweep_wreg",  32'(WriteRegister), 32'd12);
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
